ap_ctrl_seq_driver: RTL and testbench

- Synthesizable initiator for the block-level ap_ctrl_chain handshake: drives ap_start/ap_continue into an HLS top and consumes ap_ready/ap_done.
- Issues a commanded number of transactions, timestamps each start and emits one latency record per completion.
- Raises finish when every transaction has completed, so the dataflow monitor's last-transaction logic terminates.
- Supports pipelined DUTs, which may accept a new start before earlier transactions are done.

---
 rtl/ap_ctrl_pkg.sv | 30 +++
 rtl/ap_ctrl_ts_fifo.sv | 60 ++++++
 rtl/ap_ctrl_seq_driver.sv | 195 +++++++++++++++++++
 tb/tb_ap_ctrl_seq_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ap_ctrl_pkg : shared types for the ap_ctrl_chain sequence driver        |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
package ap_ctrl_pkg;

  localparam int AP_CNT_W = 16;
  localparam int AP_LAT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SPURIOUS = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // Latency record at the default widths.
  typedef struct packed {
    logic [AP_CNT_W-1:0] index;
    logic [AP_LAT_W-1:0] latency;
  } rec_t;

endpackage
`default_nettype wire

// File: rtl/ap_ctrl_ts_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ap_ctrl_ts_fifo : start-timestamp FIFO, DEPTH a power of 2 (>= 2)       |
// | Revision        : 1.0                                                   |
// +-------------------------------------------------------------------------+
module ap_ctrl_ts_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (c_AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // Push+pop on an empty FIFO is a bypass: the entry never lands in storage.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & ~(i_pop & o_empty) & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_AW'(1);
      r_count <= r_count + (c_AW+1)'(w_do_push) - (c_AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_seq_driver.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ap_ctrl_seq_driver : ap_ctrl_chain initiator with per-txn latency recs  |
// | Revision           : 1.0                                                |
// +-------------------------------------------------------------------------+
module ap_ctrl_seq_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 24,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_index,
  output logic [LAT_W-1:0] rec_latency,
  output logic             finish,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic             err,
  output logic [1:0]       err_code
);
  localparam int            c_AW      = $clog2(DEPTH);
  localparam int            c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_AW:0] c_DEPTH   = (c_AW+1)'(DEPTH);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_done;
  logic [LAT_W-1:0]  r_stamp;
  logic [c_WD_W-1:0] r_wd;
  logic              r_ap_start;
  logic              r_finish;
  logic              r_rec_valid;
  logic [CNT_W-1:0]  r_rec_index;
  logic [LAT_W-1:0]  r_rec_lat;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_rst;
  logic              w_active;
  logic              w_idle_like;
  logic              w_run_entry;
  logic              w_start_acc;
  logic              w_done_acc;
  logic              w_pop_eff;
  logic              w_spur_run;
  logic              w_spur_idle;
  logic              w_timeout;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [c_AW:0]     w_fifo_cnt;
  logic [c_AW:0]     w_out_nxt;
  logic [LAT_W-1:0]  w_head;
  logic [LAT_W-1:0]  w_lat;
  logic [CNT_W-1:0]  w_issued_nxt;

  assign w_rst       = ~reset;
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_run_entry = w_idle_like & cmd_valid & ~ap_done & (cmd_count != '0);

  assign w_start_acc  = r_ap_start & ap_ready;
  assign ap_continue  = (r_state != ST_ERR) & (~r_rec_valid | rec_ready);
  assign w_done_acc   = ap_done & ap_continue & w_active;
  assign w_pop_eff    = w_done_acc & (~w_fifo_empty | w_start_acc);
  assign w_out_nxt    = w_fifo_cnt + (c_AW+1)'(w_start_acc) - (c_AW+1)'(w_pop_eff);
  assign w_issued_nxt = r_issued + CNT_W'(w_start_acc);

  assign w_spur_run  = w_done_acc & w_fifo_empty & ~w_start_acc;
  assign w_spur_idle = ap_done & w_idle_like;
  assign w_timeout   = (TIMEOUT != 0) && w_active && (w_fifo_cnt != '0) &&
                       !w_done_acc && (r_wd == c_WD_LAST);

  // An empty FIFO at consumption means the same-cycle start is the matching one.
  assign w_lat = w_fifo_empty ? '0 : (r_stamp - w_head);

  ap_ctrl_ts_fifo #(
    .WIDTH (LAT_W),
    .DEPTH (DEPTH)
  ) u_ts_fifo (
    .clk     (clock),
    .rst     (w_rst),
    .i_clr   (w_run_entry),
    .i_push  (w_start_acc),
    .i_pop   (w_done_acc),
    .i_data  (r_stamp),
    .o_head  (w_head),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign cmd_ready   = w_idle_like;
  assign ap_start    = r_ap_start;
  assign rec_valid   = r_rec_valid;
  assign rec_index   = r_rec_index;
  assign rec_latency = r_rec_lat;
  assign finish      = r_finish;
  assign issued_cnt  = r_issued;
  assign done_cnt    = r_done;
  assign err         = r_err;
  assign err_code    = r_err_code;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_issued    <= '0;
      r_done      <= '0;
      r_stamp     <= '0;
      r_wd        <= '0;
      r_ap_start  <= 1'b0;
      r_finish    <= 1'b0;
      r_rec_valid <= 1'b0;
      r_rec_index <= '0;
      r_rec_lat   <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_stamp <= r_stamp + LAT_W'(1);

      if (!w_active || w_fifo_cnt == '0 || w_done_acc) r_wd <= '0;
      else                                            r_wd <= r_wd + c_WD_W'(1);

      if (w_done_acc && !w_spur_run) begin
        r_rec_valid <= 1'b1;
        r_rec_index <= r_done;
        r_rec_lat   <= w_lat;
        r_done      <= r_done + CNT_W'(1);
      end else if (rec_ready) begin
        r_rec_valid <= 1'b0;
      end

      if (w_start_acc) r_issued <= w_issued_nxt;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_spur_idle) begin
            r_state    <= ST_ERR;
            r_finish   <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_SPURIOUS;
          end else if (cmd_valid) begin
            r_issued <= '0;
            r_done   <= '0;
            if (cmd_count != '0) begin
              r_state    <= ST_RUN;
              r_count    <= cmd_count;
              r_stamp    <= '0;
              r_ap_start <= 1'b1;
              r_finish   <= 1'b0;
            end else begin
              r_state  <= ST_DONE;
              r_finish <= 1'b1;
            end
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (w_spur_run || w_timeout) begin
            r_state    <= ST_ERR;
            r_ap_start <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= w_spur_run ? ERR_SPURIOUS : ERR_TIMEOUT;
          end else if (r_state == ST_RUN) begin
            r_ap_start <= (w_issued_nxt < r_count) && (w_out_nxt < c_DEPTH);
            if (w_issued_nxt == r_count) r_state <= ST_DRAIN;
          end else if (r_done == r_count && !r_rec_valid) begin
            r_state  <= ST_DONE;
            r_finish <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_ERR;
          r_ap_start <= 1'b0;
          r_finish   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_seq_driver.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ap_ctrl_seq_driver : bench with an HLS-block model and record model  |
// | Revision              : 1.0                                             |
// +-------------------------------------------------------------------------+
module tb_ap_ctrl_seq_driver;
  import ap_ctrl_pkg::*;

  localparam int CNT_W = 16;
  localparam int LAT_W = 24;
  localparam int DEPTH = 4;
  localparam int TOUT  = 50;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             ap_start;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue;
  logic             rec_valid;
  logic             rec_ready = 1'b1;
  logic [CNT_W-1:0] rec_index;
  logic [LAT_W-1:0] rec_latency;
  logic             finish;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic             err;
  logic [1:0]       err_code;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t obs_q[$];
  int   max_out;

  ap_ctrl_seq_driver #(
    .CNT_W(CNT_W), .LAT_W(LAT_W), .DEPTH(DEPTH), .TIMEOUT(TOUT)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_index(rec_index), .rec_latency(rec_latency), .finish(finish),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt), .err(err), .err_code(err_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; cmd_valid = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; rec_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Plays the HLS block (in-order completion, done held until continue) and
  // predicts every record from the handshakes seen at the interface.
  task automatic drive_run(input int n, input int lat_lo, input int lat_hi, input bit pipe,
                           input int rdy_pct, input int rr_pct, input int bp_at, input int bp_len);
    int  due_q[$];
    int  acc_q[$];
    int  exp_idx[$];
    int  exp_lat[$];
    int  issued = 0;
    int  consumed = 0;
    bit  wait_start = 1'b0;
    bit  s_acc, d_acc, take, seen_fin;
    obs_q.delete();
    max_out  = 0;
    seen_fin = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_count = CNT_W'(n);
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      ap_ready  = (pipe || due_q.size() == 0) && ($urandom_range(99, 0) < rdy_pct);
      ap_done   = 1'b0;
      if (due_q.size() != 0) ap_done = (cyc >= due_q[0]);
      rec_ready = (k >= bp_at && k < bp_at + bp_len) ? 1'b0 : ($urandom_range(99, 0) < rr_pct);
      #1;
      if (finish === 1'b1) begin seen_fin = 1'b1; break; end
      checks++;
      if (ap_continue !== (!rec_valid || rec_ready)) begin
        errors++; $display("FAIL ap_continue cyc %0d got %b want %b", cyc, ap_continue, !rec_valid || rec_ready);
      end
      if (wait_start) begin
        checks++;
        if (ap_start !== 1'b1) begin errors++; $display("FAIL start_hold cyc %0d got %b want 1", cyc, ap_start); end
      end
      checks++;
      if (ap_start === 1'b1 && (issued >= n || issued - consumed >= DEPTH)) begin
        errors++; $display("FAIL over_issue cyc %0d issued %0d outstanding %0d", cyc, issued, issued - consumed);
      end
      s_acc = (ap_start === 1'b1) && ap_ready;
      d_acc = ap_done && (ap_continue === 1'b1);
      take  = (rec_valid === 1'b1) && rec_ready;
      if (take) begin
        checks++;
        if (exp_idx.size() == 0) begin
          errors++; $display("FAIL rec_extra idx got %0d want none", rec_index);
        end else begin
          if (rec_index !== CNT_W'(exp_idx[0]) || rec_latency !== LAT_W'(exp_lat[0])) begin
            errors++;
            $display("FAIL rec got idx %0d lat %0d want idx %0d lat %0d", rec_index, rec_latency, exp_idx[0], exp_lat[0]);
          end
          void'(exp_idx.pop_front()); void'(exp_lat.pop_front());
        end
        obs_q.push_back('{index: rec_index, latency: rec_latency});
      end
      if (s_acc) begin
        acc_q.push_back(cyc);
        due_q.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        issued++;
      end
      if (d_acc && acc_q.size() != 0) begin
        exp_idx.push_back(consumed);
        exp_lat.push_back(cyc - acc_q.pop_front());
        void'(due_q.pop_front());
        consumed++;
      end
      if (issued - consumed > max_out) max_out = issued - consumed;
      wait_start = (ap_start === 1'b1) && !ap_ready && (issued < n);
      @(negedge clock);
    end
    ap_ready = 1'b0; ap_done = 1'b0; rec_ready = 1'b1;
    checks++;
    if (!seen_fin) begin errors++; $display("FAIL finish_timeout got 0 want 1 (n=%0d)", n); end
    checks++;
    if (issued_cnt !== CNT_W'(n) || done_cnt !== CNT_W'(n)) begin
      errors++; $display("FAIL counts got %0d/%0d want %0d/%0d", issued_cnt, done_cnt, n, n);
    end
    checks++;
    if (obs_q.size() != n || err !== 1'b0) begin
      errors++; $display("FAIL records got %0d err %b want %0d err 0", obs_q.size(), err, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({ap_start, rec_valid, finish, err, ap_continue, cmd_ready} !== 6'b000011 ||
        err_code !== ERR_NONE || issued_cnt !== '0 || done_cnt !== '0) begin
      errors++;
      $display("FAIL reset got st%b rv%b fin%b err%b cont%b rdy%b code%0d want 0 0 0 0 1 1 0",
               ap_start, rec_valid, finish, err, ap_continue, cmd_ready, err_code);
    end
  endtask

  task automatic test_basic();
    drive_run(3, 5, 5, 1'b0, 100, 100, 9999, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].index !== AP_CNT_W'(i) || obs_q[i].latency !== AP_LAT_W'(5)) begin
        errors++; $display("FAIL basic[%0d] got idx %0d lat %0d want idx %0d lat 5", i, obs_q[i].index, obs_q[i].latency, i);
      end
    end
    checks++;
    if (finish !== 1'b1) begin errors++; $display("FAIL basic_finish got %b want 1", finish); end
  endtask

  task automatic test_pipelined();
    drive_run(8, 10, 10, 1'b1, 100, 100, 9999, 0);
    checks++;
    if (max_out != DEPTH) begin errors++; $display("FAIL pipe_outstanding got %0d want %0d", max_out, DEPTH); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].index !== AP_CNT_W'(i) || obs_q[i].latency !== AP_LAT_W'(10)) begin
        errors++; $display("FAIL pipe[%0d] got idx %0d lat %0d want idx %0d lat 10", i, obs_q[i].index, obs_q[i].latency, i);
      end
    end
  endtask

  task automatic test_backpressure();
    int worst = 0;
    drive_run(6, 4, 4, 1'b1, 100, 100, 8, 20);
    for (int i = 0; i < obs_q.size(); i++)
      if (int'(obs_q[i].latency) > worst) worst = int'(obs_q[i].latency);
    checks++;
    if (worst <= 4) begin errors++; $display("FAIL bp_latency got max %0d want > 4", worst); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      drive_run(int'($urandom_range(20, 1)), 1, 12, 1'($urandom_range(1, 0)),
                int'($urandom_range(100, 60)), int'($urandom_range(100, 50)), 9999, 0);
  endtask

  task automatic test_zero_count();
    bit any_start = 1'b0;
    apply_reset();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_count = '0;
    @(negedge clock);
    cmd_valid = 1'b0;
    checks++;
    if (finish !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL zero_finish got fin %b rdy %b want 1 1", finish, cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ap_start !== 1'b0) any_start = 1'b1;
    end
    checks++;
    if (any_start) begin errors++; $display("FAIL zero_start got 1 want 0"); end
  endtask

  task automatic test_spurious();
    bit any_start = 1'b0;
    apply_reset();
    @(negedge clock);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    checks++;
    if (err !== 1'b1 || err_code !== ERR_SPURIOUS) begin
      errors++; $display("FAIL spurious got err %b code %0d want 1 1", err, err_code);
    end
    cmd_valid = 1'b1; cmd_count = 16'd3; ap_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ap_start !== 1'b0) any_start = 1'b1;
    end
    cmd_valid = 1'b0; ap_ready = 1'b0;
    checks++;
    if (any_start || err !== 1'b1 || cmd_ready !== 1'b0 || ap_continue !== 1'b0) begin
      errors++; $display("FAIL err_hold got start %b err %b rdy %b cont %b want 0 1 0 0", any_start, err, cmd_ready, ap_continue);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_count = 16'd1;
    @(negedge clock);
    cmd_valid = 1'b0; ap_ready = 1'b1;
    #1;
    checks++;
    if (ap_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", ap_start); end
    @(posedge clock);
    @(negedge clock);
    ap_ready = 1'b0;
    for (int k = 1; k <= TOUT; k++) begin
      @(posedge clock);
      #1;
      if (k == TOUT - 1) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL to_early got err %b at %0d want 0", err, k); end
      end
      if (k == TOUT) begin
        checks++;
        if (err !== 1'b1 || err_code !== ERR_TIMEOUT) begin
          errors++; $display("FAIL to_fire got err %b code %0d want 1 2", err, err_code);
        end
      end
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if ({ap_start, rec_valid, finish, err, ap_continue, cmd_ready} !== 6'b000011 ||
        err_code !== ERR_NONE || issued_cnt !== '0 || done_cnt !== '0) begin
      errors++; $display("FAIL to_reset got st%b rv%b fin%b err%b cont%b rdy%b code%0d",
                         ap_start, rec_valid, finish, err, ap_continue, cmd_ready, err_code);
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_count = 16'd5;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ap_start !== 1'b1) begin errors++; $display("FAIL mid_start got %b want 1", ap_start); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (ap_start !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got start %b rdy %b want 0 1", ap_start, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pipelined();
    test_backpressure();
    test_random();
    test_zero_count();
    test_spurious();
    test_timeout();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
